cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter ROM_AW, default 15, instruction ROM address width (matches 15-bit pc).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_op input 2: command handshake; op 00 RUN, 01 HALT, 10 STEP, 11 LOAD.
REQ-005 SHALL have port ld_count  input  ROM_AW  number of words to load, sampled when LOAD is accepted.
REQ-006 SHALL have ports ld_valid input 1, ld_ready output 1, ld_data input 16: program-word stream.
REQ-007 SHALL have ports rom_we output 1, rom_addr output ROM_AW, rom_wdata output 16: ROM write port.
REQ-008 SHALL have ports bp_en input 1, bp_addr input ROM_AW: single breakpoint.
REQ-009 SHALL have port pc  input  ROM_AW  current CPU program counter.
REQ-010 SHALL have ports cpu_reset output 1 (active-high CPU reset), cpu_ce output 1 (CPU clock enable).
REQ-011 SHALL have ports state output 3 (HOLD=0, LOAD=1, RUN=2, HALT=3, STEP=4), bp_hit output 1.

Function
REQ-012 SHALL implement FSM states HOLD, LOAD, RUN, HALT, STEP; a command is accepted only on cmd_valid & cmd_ready.
REQ-013 cmd_ready SHALL be 1 in HOLD, HALT, RUN; 0 in LOAD, STEP, and in any RUN cycle where a breakpoint matches (REQ-021).
REQ-014 HOLD: RUN->RUN, STEP->STEP, LOAD->LOAD (ld_count>0) or stay HOLD (ld_count=0), HALT->no-op.
REQ-015 HALT: RUN->RUN, STEP->STEP, LOAD->LOAD/HOLD per REQ-014, HALT->no-op.
REQ-016 RUN: HALT->HALT, LOAD->LOAD/HOLD per REQ-014, RUN and STEP->no-op (accepted, discarded).
REQ-017 LOAD: ld_ready=1; rom_we=ld_valid&ld_ready combinationally; rom_addr=word counter (starts 0); rom_wdata=ld_data.
REQ-018 LOAD: counter increments per accepted word; on acceptance of word ld_count-1, next state HOLD, counter cleared; ld_ready=0 outside LOAD.
REQ-019 cpu_reset SHALL be a flop output, 1 exactly while state is HOLD or LOAD (glitch-free); so first RUN/STEP cycle after HOLD executes from pc=0.
REQ-020 cpu_ce SHALL be 1 in STEP, and in RUN unless breakpoint match; 0 in HOLD, LOAD, HALT.
REQ-021 Breakpoint match: state RUN & bp_en & pc==bp_addr & !skip; on match cpu_ce=0 that cycle, next state HALT, bp_hit set to 1.
REQ-022 skip flag SHALL be set when entering RUN from HALT, cleared after the first RUN cycle, so resume from a breakpoint executes that instruction.
REQ-023 STEP SHALL last exactly one cycle (one cpu_ce pulse), then HALT; breakpoints ignored in STEP.
REQ-024 bp_hit SHALL clear on acceptance of any command.
REQ-025 Breakpoint match and pending cmd same cycle: breakpoint wins, command held (cmd_ready=0) and accepted in HALT next cycle.

Reset
REQ-026 reset_n low SHALL immediately force state=HOLD, cpu_reset=1, cpu_ce=0, cmd_ready=1, ld_ready=0, rom_we=0, rom_addr=0, bp_hit=0, skip=0, counter=0.
REQ-027 reset_n during LOAD SHALL abandon the load; already-written ROM words are not undone; next LOAD restarts at address 0.

Verification
REQ-028 LOAD ld_count=3, words 0x0005,0xEC10,0x0000 with ld_valid gaps -> rom_we thrice at addr 0,1,2; then HOLD, cpu_reset=1.
REQ-029 HOLD, RUN -> next cycle state=RUN, cpu_reset=0, cpu_ce=1; HALT cmd -> following cycle cpu_ce=0, state=HALT.
REQ-030 RUN, bp_en=1, bp_addr=4, pc reaches 4 -> cpu_ce=0 that cycle, state=HALT, bp_hit=1; RUN -> pc 4 executes, pc advances to 5.
REQ-031 HALT, STEP -> exactly one cpu_ce pulse, cmd_ready=0 during it, then HALT.
REQ-032 LOAD with ld_count=0 -> accepted, stays HOLD, no rom_we; reset_n low mid-LOAD after 2 of 5 words -> HOLD, rom_addr=0.
REQ-033 cmd_valid with HALT in same cycle as breakpoint match -> cmd_ready=0, state=HALT next cycle, cmd accepted then, bp_hit cleared.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step/load controller for a small CPU.
// Loads program words into the instruction ROM, holds the CPU in reset
// while idle or loading, and gates the CPU clock enable for free-running,
// single-step and breakpoint-halt operation.
module cpu_run_ctrl #(
    parameter int ROM_AW = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ROM_AW-1:0] ld_count,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [15:0]       ld_data,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    input  logic              bp_en,
    input  logic [ROM_AW-1:0] bp_addr,
    input  logic [ROM_AW-1:0] pc,
    output logic              cpu_reset,
    output logic              cpu_ce,
    output logic [2:0]        state,
    output logic              bp_hit
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_STEP = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [ROM_AW-1:0]   r_cnt;
    logic [ROM_AW-1:0]   r_len;
    logic                r_skip;
    logic                r_bp_hit;
    logic                r_cpu_reset;
    logic                w_bp_match;
    logic                w_cmd_acc;
    logic                w_word_acc;
    logic                w_last_word;
    logic                w_load_start;
    state_t              w_load_dest;

    // Breakpoint detect, handshakes and combinational outputs
    always_comb begin
        w_bp_match   = 1'b0;
        cmd_ready    = 1'b0;
        ld_ready     = 1'b0;
        cpu_ce       = 1'b0;
        w_bp_match   = (r_state == S_RUN) && bp_en && (pc == bp_addr) && !r_skip;
        cmd_ready    = ((r_state == S_HOLD) || (r_state == S_HALT) || (r_state == S_RUN))
                       && !w_bp_match;
        ld_ready     = (r_state == S_LOAD);
        cpu_ce       = (r_state == S_STEP) || ((r_state == S_RUN) && !w_bp_match);
    end

    assign w_cmd_acc    = cmd_valid && cmd_ready;
    assign w_word_acc   = ld_valid && ld_ready;
    assign w_last_word  = (r_cnt == r_len - ROM_AW'(1));
    assign w_load_start = w_cmd_acc && (cmd_op == OP_LOAD) && (ld_count != '0);
    // A zero-length load is accepted but leaves the CPU parked in HOLD.
    assign w_load_dest  = (ld_count != '0) ? S_LOAD : S_HOLD;

    assign rom_we    = w_word_acc;
    assign rom_addr  = r_cnt;
    assign rom_wdata = ld_data;
    assign state     = r_state;
    assign bp_hit    = r_bp_hit;
    assign cpu_reset = r_cpu_reset;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HOLD, S_HALT: begin
                if (w_cmd_acc) begin
                    unique case (cmd_op)
                        OP_RUN:  w_next = S_RUN;
                        OP_STEP: w_next = S_STEP;
                        OP_LOAD: w_next = w_load_dest;
                        OP_HALT: w_next = r_state;
                        default: w_next = r_state;
                    endcase
                end
            end
            S_RUN: begin
                // A breakpoint takes priority; any pending command waits for HALT.
                if (w_bp_match) begin
                    w_next = S_HALT;
                end else if (w_cmd_acc) begin
                    if (cmd_op == OP_HALT) begin
                        w_next = S_HALT;
                    end else if (cmd_op == OP_LOAD) begin
                        w_next = w_load_dest;
                    end
                end
            end
            S_LOAD: begin
                if (w_word_acc && w_last_word) begin
                    w_next = S_HOLD;
                end
            end
            S_STEP: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HOLD;
            end
        endcase
    end

    // State, flags and registered CPU reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_HOLD;
            r_skip      <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state     <= w_next;
            // Resuming from HALT must execute the instruction at the breakpoint.
            r_skip      <= (r_state == S_HALT) && (w_next == S_RUN);
            r_cpu_reset <= (w_next == S_HOLD) || (w_next == S_LOAD);
            if (w_bp_match) begin
                r_bp_hit <= 1'b1;
            end else if (w_cmd_acc) begin
                r_bp_hit <= 1'b0;
            end
        end
    end

    // Load word counter; cleared at load start, load end and reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_load_start) begin
            r_cnt <= '0;
        end else if (w_word_acc) begin
            r_cnt <= w_last_word ? '0 : r_cnt + ROM_AW'(1);
        end
    end

    // Load length captured when a LOAD command is accepted
    always_ff @(posedge clk) begin
        if (w_load_start) begin
            r_len <= ld_count;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl with a minimal CPU program-counter model.
module tb_cpu_run_ctrl;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] ld_count;
    logic          ld_valid;
    logic          ld_ready;
    logic [15:0]   ld_data;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_wdata;
    logic          bp_en;
    logic [AW-1:0] bp_addr;
    logic [AW-1:0] pc;
    logic          cpu_reset;
    logic          cpu_ce;
    logic [2:0]    state;
    logic          bp_hit;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl #(.ROM_AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .ld_count  (ld_count),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_reset (cpu_reset),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    // CPU model: pc cleared while held in reset, advances on each enabled cycle
    always_ff @(posedge clk) begin
        if (cpu_reset) pc <= '0;
        else if (cpu_ce) pc <= pc + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; ld_count = '0;
        ld_valid = 1'b0; ld_data = '0; bp_en = 1'b0; bp_addr = '0;
        tick(); tick(); settle();
        chk("rst_state", state, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_rom_we", rom_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_bp_hit", bp_hit, 0);
        reset_n = 1'b1;

        // HALT in HOLD is a no-op
        tick(); cmd_valid = 1; cmd_op = 2'b01; settle();
        tick(); cmd_valid = 0; settle();
        chk("hold_halt_noop", state, 0);

        // LOAD 3 words with gaps on ld_valid
        cmd_valid = 1; cmd_op = 2'b11; ld_count = 3; settle();
        chk("load_cmd_ready", cmd_ready, 1);
        tick(); cmd_valid = 0; ld_count = 7; settle();
        chk("load_state", state, 1);
        chk("load_ld_ready", ld_ready, 1);
        chk("load_cpu_reset", cpu_reset, 1);
        chk("load_cmd_busy", cmd_ready, 0);
        chk("load_gap_we", rom_we, 0);
        tick(); ld_valid = 1; ld_data = 16'h0005; settle();
        chk("w0_we", rom_we, 1);
        chk("w0_addr", rom_addr, 0);
        chk("w0_data", rom_wdata, 16'h0005);
        tick(); ld_valid = 0; settle();
        chk("gap_we", rom_we, 0);
        chk("gap_addr", rom_addr, 1);
        tick(); ld_valid = 1; ld_data = 16'hEC10; settle();
        chk("w1_addr", rom_addr, 1);
        chk("w1_data", rom_wdata, 16'hEC10);
        tick(); ld_data = 16'h0000; settle();
        chk("w2_we", rom_we, 1);
        chk("w2_addr", rom_addr, 2);
        tick(); ld_valid = 0; settle();
        chk("load_done_state", state, 0);
        chk("load_done_cpu_reset", cpu_reset, 1);
        chk("load_done_ld_ready", ld_ready, 0);
        chk("load_done_addr", rom_addr, 0);

        // RUN from HOLD, then HALT
        cmd_valid = 1; cmd_op = 2'b00;
        tick(); cmd_valid = 0; settle();
        chk("run_state", state, 2);
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_cpu_ce", cpu_ce, 1);
        chk("run_pc0", pc, 0);
        // RUN in RUN is accepted and discarded
        cmd_valid = 1; cmd_op = 2'b00; settle();
        chk("run_run_ready", cmd_ready, 1);
        tick(); cmd_valid = 1; cmd_op = 2'b01; settle();
        chk("run_still", state, 2);
        chk("run_pc1", pc, 1);
        tick(); cmd_valid = 0; settle();
        chk("halt_state", state, 3);
        chk("halt_cpu_ce", cpu_ce, 0);
        chk("halt_pc", pc, 2);
        tick(); settle();
        chk("halt_pc_hold", pc, 2);

        // Breakpoint at 4, then resume executes pc 4
        bp_en = 1; bp_addr = 4; cmd_valid = 1; cmd_op = 2'b00;
        tick(); cmd_valid = 0; settle();
        chk("bp_run_pc2", pc, 2);
        tick(); settle();
        chk("bp_run_pc3", pc, 3);
        tick(); settle();
        chk("bp_pc4", pc, 4);
        chk("bp_ce_low", cpu_ce, 0);
        chk("bp_ready_low", cmd_ready, 0);
        tick(); settle();
        chk("bp_state_halt", state, 3);
        chk("bp_hit_set", bp_hit, 1);
        chk("bp_pc_held", pc, 4);
        cmd_valid = 1; cmd_op = 2'b00;
        tick(); cmd_valid = 0; settle();
        chk("resume_state", state, 2);
        chk("resume_bp_hit_clr", bp_hit, 0);
        chk("resume_ce", cpu_ce, 1);
        tick(); settle();
        chk("resume_pc5", pc, 5);
        bp_en = 0; cmd_valid = 1; cmd_op = 2'b01;
        tick(); cmd_valid = 0; settle();
        chk("halt2_state", state, 3);
        chk("halt2_pc", pc, 6);

        // Single step
        cmd_valid = 1; cmd_op = 2'b10;
        tick(); cmd_valid = 0; settle();
        chk("step_state", state, 4);
        chk("step_ce", cpu_ce, 1);
        chk("step_ready", cmd_ready, 0);
        tick(); settle();
        chk("step_back_halt", state, 3);
        chk("step_ce_off", cpu_ce, 0);
        chk("step_pc", pc, 7);

        // Breakpoint coincides with pending HALT command
        bp_en = 1; bp_addr = 8; cmd_valid = 1; cmd_op = 2'b00;
        tick(); cmd_valid = 0; settle();
        chk("coll_run_pc7", pc, 7);
        tick(); cmd_valid = 1; cmd_op = 2'b01; settle();
        chk("coll_pc8", pc, 8);
        chk("coll_ready_low", cmd_ready, 0);
        chk("coll_ce_low", cpu_ce, 0);
        tick(); settle();
        chk("coll_halt", state, 3);
        chk("coll_bp_hit", bp_hit, 1);
        chk("coll_ready_halt", cmd_ready, 1);
        tick(); cmd_valid = 0; bp_en = 0; settle();
        chk("coll_state", state, 3);
        chk("coll_bp_clr", bp_hit, 0);

        // Zero-length LOAD from HALT goes to HOLD with no writes
        cmd_valid = 1; cmd_op = 2'b11; ld_count = 0; ld_valid = 1;
        tick(); cmd_valid = 0; settle();
        chk("ld0_state", state, 0);
        chk("ld0_we", rom_we, 0);
        chk("ld0_cpu_reset", cpu_reset, 1);

        // Reset in the middle of a 5-word load
        ld_valid = 0; cmd_valid = 1; cmd_op = 2'b11; ld_count = 5;
        tick(); cmd_valid = 0; ld_valid = 1; ld_data = 16'h1111; settle();
        chk("ld5_w0_addr", rom_addr, 0);
        tick(); ld_data = 16'h2222; settle();
        chk("ld5_w1_addr", rom_addr, 1);
        tick(); ld_valid = 0; settle();
        chk("ld5_addr2", rom_addr, 2);
        reset_n = 0; ld_valid = 1; settle();
        chk("abort_state", state, 0);
        chk("abort_addr", rom_addr, 0);
        chk("abort_we", rom_we, 0);
        chk("abort_ld_ready", ld_ready, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        tick(); reset_n = 1; ld_valid = 0;

        // Next load restarts at address 0
        tick(); cmd_valid = 1; cmd_op = 2'b11; ld_count = 1;
        tick(); cmd_valid = 0; ld_valid = 1; ld_data = 16'hABCD; settle();
        chk("reload_addr", rom_addr, 0);
        chk("reload_we", rom_we, 1);
        tick(); ld_valid = 0; settle();
        chk("reload_done", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so a hung run still ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
